// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_reg_seq burst shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SM_LOGIC,
    SM_ARITH,
    SM_ROT,
    SM_SERIAL
  } shift_mode_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift of a WIDTH-bit word; the only place the fill rules live,
// so the manual and burst paths cannot disagree.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  shift_mode_t      mode_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  logic fillBit;

  always_comb begin
    fillBit   = 1'b0;
    out_bit_o = 1'b0;
    data_o    = data_i;
    if (dir_i == DIR_LEFT) begin
      out_bit_o = data_i[WIDTH-1];
      // Arithmetic left behaves like logical left: zero enters at the LSB.
      case (mode_i)
        SM_ROT:    fillBit = data_i[WIDTH-1];
        SM_SERIAL: fillBit = serial_i;
        default:   fillBit = 1'b0;
      endcase
      data_o = {data_i[WIDTH-2:0], fillBit};
    end else begin
      out_bit_o = data_i[0];
      case (mode_i)
        SM_ARITH:  fillBit = data_i[WIDTH-1];
        SM_ROT:    fillBit = data_i[0];
        SM_SERIAL: fillBit = serial_i;
        default:   fillBit = 1'b0;
      endcase
      data_o = {fillBit, data_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Shift register with parallel load and an autonomous burst sequencer that
// performs Count single-bit shifts, reporting progress via Busy/Done.
module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Shift,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic             Serial_in,
  output logic [WIDTH-1:0] Data_out,
  output logic             Serial_out,
  output logic             Busy,
  output logic             Done
);

  state_t           state_q;
  logic [CNT_W-1:0] remain_q;
  logic             dir_q;
  shift_mode_t      mode_q;
  logic [WIDTH-1:0] data_q;
  logic             sout_q;
  logic             done_q;

  logic             stepDir;
  shift_mode_t      stepMode;
  logic [WIDTH-1:0] data_d;
  logic             outBit_d;

  // A running burst uses the settings captured at Start; idle shifts use live ones.
  always_comb begin
    stepDir  = Dir;
    stepMode = shift_mode_t'(Mode);
    if (state_q == S_RUN) begin
      stepDir  = dir_q;
      stepMode = mode_q;
    end
  end

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data_i   (data_q),
    .dir_i    (stepDir),
    .mode_i   (stepMode),
    .serial_i (Serial_in),
    .data_o   (data_d),
    .out_bit_o(outBit_d)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      dir_q    <= DIR_RIGHT;
      mode_q   <= SM_LOGIC;
      data_q   <= '0;
      sout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Load) begin
        data_q   <= Data_in;
        state_q  <= S_IDLE;
        remain_q <= '0;
      end else if (state_q == S_IDLE) begin
        if (Start) begin
          dir_q    <= Dir;
          mode_q   <= shift_mode_t'(Mode);
          remain_q <= Count;
          if (Count == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= S_RUN;
          end
        end else if (Shift) begin
          data_q <= data_d;
          sout_q <= outBit_d;
        end
      end else begin
        data_q   <= data_d;
        sout_q   <= outBit_d;
        remain_q <= remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign Data_out   = data_q;
  assign Serial_out = sout_q;
  assign Busy       = (state_q == S_RUN);
  assign Done       = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed scenarios plus random traffic, all
// compared against an arithmetic reference model every cycle.
module tb_shift_reg_seq;
  import shift_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB_W = 1 << (WIDTH - 1);
  localparam int MOD_W = 1 << WIDTH;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b1;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] Data_in = '0;
  logic             Shift = 1'b0;
  logic             Start = 1'b0;
  logic [CNT_W-1:0] Count = '0;
  logic             Dir = 1'b0;
  logic [1:0]       Mode = 2'b00;
  logic             Serial_in = 1'b0;
  logic [WIDTH-1:0] Data_out;
  logic             Serial_out;
  logic             Busy;
  logic             Done;

  int compareCount = 0;
  int mismatchCount = 0;

  int mData;
  bit mSout;
  bit mBusy;
  bit mDone;
  int mRem;
  bit mDir;
  int mMode;

  shift_reg_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Load      (Load),
    .Data_in   (Data_in),
    .Shift     (Shift),
    .Start     (Start),
    .Count     (Count),
    .Dir       (Dir),
    .Mode      (Mode),
    .Serial_in (Serial_in),
    .Data_out  (Data_out),
    .Serial_out(Serial_out),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Shifting as multiply/divide by two on an integer, fill added back in.
  function automatic void shiftOne(input bit dir, input int mode, input bit sin);
    int fill;
    int outBit;
    if (dir) begin
      outBit = (mData / MSB_W) % 2;
      fill   = (mode == 2) ? outBit : (mode == 3) ? int'(sin) : 0;
      mData  = (mData * 2) % MOD_W + fill;
    end else begin
      outBit = mData % 2;
      fill   = (mode == 1) ? mData / MSB_W : (mode == 2) ? outBit : (mode == 3) ? int'(sin) : 0;
      mData  = mData / 2 + fill * MSB_W;
    end
    mSout = (outBit != 0);
  endfunction

  function automatic void modelReset();
    mData = 0;
    mSout = 0;
    mBusy = 0;
    mDone = 0;
    mRem  = 0;
    mDir  = 0;
    mMode = 0;
  endfunction

  function automatic void modelEdge();
    bit nDone;
    nDone = 0;
    if (Load) begin
      mData = int'(Data_in);
      mBusy = 0;
      mRem  = 0;
    end else if (!mBusy) begin
      if (Start) begin
        mDir  = Dir;
        mMode = int'(Mode);
        if (Count == 0) begin
          nDone = 1;
        end else begin
          mBusy = 1;
          mRem  = int'(Count);
        end
      end else if (Shift) begin
        shiftOne(Dir, int'(Mode), Serial_in);
      end
    end else begin
      shiftOne(mDir, mMode, Serial_in);
      mRem--;
      if (mRem == 0) begin
        mBusy = 0;
        nDone = 1;
      end
    end
    mDone = nDone;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "_data"}, 32'(Data_out), 32'(mData));
    checkOutput({tag, "_sout"}, 32'(Serial_out), 32'(mSout));
    checkOutput({tag, "_busy"}, 32'(Busy), 32'(mBusy));
    checkOutput({tag, "_done"}, 32'(Done), 32'(mDone));
  endtask

  // Inputs change at edge+1, the model steps on the edge, outputs are sampled at edge+1.
  task automatic applyStimulus(input bit ld, input int din, input bit sh, input bit st, input int cnt,
                               input bit dir, input int mode, input bit sin, input string tag);
    Load      = ld;
    Data_in   = din[WIDTH-1:0];
    Shift     = sh;
    Start     = st;
    Count     = cnt[CNT_W-1:0];
    Dir       = dir;
    Mode      = mode[1:0];
    Serial_in = sin;
    @(posedge Clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycles(input int n, input bit sin, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, sin, tag);
  endtask

  task automatic asyncReset(input string tag);
    #2;
    Reset_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    #1;
    Reset_n = 1'b0;
    #1;
    checkAll("reset");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Rotate left by 4 from 0x8001.
    applyStimulus(1, 'h8001, 0, 0, 0, 0, 0, 0, "s1_load");
    applyStimulus(0, 0, 0, 1, 4, DIR_LEFT, 2, 0, "s1_start");
    idleCycles(4, 0, "s1_run");
    checkOutput("s1_final_data", 32'(Data_out), 32'h0018);
    checkOutput("s1_final_done", 32'(Done), 32'd1);
    checkOutput("s1_final_sout", 32'(Serial_out), 32'd0);
    idleCycles(1, 0, "s1_after");
    checkOutput("s1_done_clear", 32'(Done), 32'd0);

    // Arithmetic right from 0x8000.
    applyStimulus(1, 'h8000, 0, 0, 0, 0, 0, 0, "s2_load");
    applyStimulus(0, 0, 0, 1, 3, DIR_RIGHT, 1, 0, "s2_start");
    idleCycles(1, 0, "s2_run");
    checkOutput("s2_step1", 32'(Data_out), 32'hC000);
    idleCycles(1, 0, "s2_run");
    checkOutput("s2_step2", 32'(Data_out), 32'hE000);
    checkOutput("s2_step2_done", 32'(Done), 32'd0);
    idleCycles(1, 0, "s2_run");
    checkOutput("s2_step3", 32'(Data_out), 32'hF000);
    checkOutput("s2_step3_done", 32'(Done), 32'd1);

    // Serial fill of ones across the full width.
    applyStimulus(1, 'h0000, 0, 0, 0, 0, 0, 1, "s3_load");
    applyStimulus(0, 0, 0, 1, 16, DIR_RIGHT, 3, 1, "s3_start");
    idleCycles(16, 1, "s3_run");
    checkOutput("s3_data", 32'(Data_out), 32'hFFFF);
    checkOutput("s3_sout", 32'(Serial_out), 32'd0);

    // Manual shifts, then a zero-length burst.
    applyStimulus(1, 'h00FF, 0, 0, 0, 0, 0, 0, "s4_load");
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 0, DIR_LEFT, 0, 0, "s4_shift");
    checkOutput("s4_data", 32'(Data_out), 32'hFF00);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, "s4_start0");
    checkOutput("s4_zero_done", 32'(Done), 32'd1);
    checkOutput("s4_zero_busy", 32'(Busy), 32'd0);
    checkOutput("s4_zero_data", 32'(Data_out), 32'hFF00);

    // Load aborts a burst; Start ignored while running, accepted in the Done cycle.
    applyStimulus(1, 'h1234, 0, 0, 0, 0, 0, 0, "s5_load");
    applyStimulus(0, 0, 0, 1, 10, DIR_RIGHT, 0, 0, "s5_start");
    applyStimulus(0, 0, 0, 1, 5, DIR_LEFT, 2, 0, "s5_ignored_start");
    idleCycles(1, 0, "s5_run");
    applyStimulus(1, 'hABCD, 0, 0, 0, 0, 0, 0, "s5_abort");
    checkOutput("s5_abort_data", 32'(Data_out), 32'hABCD);
    checkOutput("s5_abort_busy", 32'(Busy), 32'd0);
    checkOutput("s5_abort_done", 32'(Done), 32'd0);
    applyStimulus(0, 0, 0, 1, 2, DIR_LEFT, 0, 0, "s5_start2");
    idleCycles(2, 0, "s5_run2");
    checkOutput("s5_done_pulse", 32'(Done), 32'd1);
    applyStimulus(0, 0, 0, 1, 3, DIR_RIGHT, 2, 0, "s5_start_in_done");
    checkOutput("s5_accept_busy", 32'(Busy), 32'd1);
    idleCycles(3, 0, "s5_run3");
    checkOutput("s5_done2", 32'(Done), 32'd1);

    // Asynchronous reset mid-burst.
    applyStimulus(0, 0, 0, 1, 12, DIR_LEFT, 2, 0, "s6_start");
    idleCycles(3, 0, "s6_run");
    asyncReset("s6_reset");
    applyStimulus(0, 0, 1, 0, 0, DIR_LEFT, 0, 0, "s6_shift");
    checkOutput("s6_data", 32'(Data_out), 32'd0);
    checkOutput("s6_sout", 32'(Serial_out), 32'd0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        asyncReset("rnd_reset");
      end else begin
        applyStimulus($urandom_range(0, 19) == 0, int'($urandom_range(0, 65535)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                      int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised shift register with parallel load, four fill modes and a built-in burst sequencer. It runs a programmed number of single-bit shifts autonomously and signals completion with a Busy/Done handshake. It is the datapath/control successor to the fixed-width load registers, for shift-add multiplier and serial-conversion datapaths.

## Interface
- WIDTH, 16, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of the shift count
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Load  in  1  parallel load of Data_in
- Data_in  in  WIDTH  parallel load value
- Shift  in  1  single manual shift step (idle only)
- Start  in  1  begin burst of Count shifts (idle only)
- Count  in  CNT_W  burst length, latched on accepted Start
- Dir  in  1  0 = right (toward LSB), 1 = left
- Mode  in  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 serial
- Serial_in  in  1  fill bit in serial mode
- Data_out  out  WIDTH  register contents
- Serial_out  out  1  last bit shifted out (registered)
- Busy  out  1  burst in progress
- Done  out  1  one-cycle pulse at burst completion

## Operation
- Fill bit per shift: logical → 0; arithmetic → MSB on right, 0 on left; rotate → outgoing bit; serial → Serial_in.
- Outgoing bit: LSB on right, MSB on left. It is copied to Serial_out on every shift, whether manual or burst.
- FSM states: IDLE, RUN.
- Priority each edge: Load > Start > Shift > hold.
- Load works in any state:
  - Data_out ← Data_in.
  - In RUN, the burst aborts: next state IDLE, Busy → 0, no Done pulse.
  - Serial_out is unchanged.
- Start in IDLE latches Count, Dir and Mode into internal registers.
  - Count = 0 → stay IDLE, Done pulses, data unchanged.
  - Count ≠ 0 → go to RUN.
- RUN:
  - Shift once per cycle using the latched Dir/Mode. Live Dir/Mode are ignored.
  - Decrement the remaining count.
  - The shift that takes remaining from 1 to 0 also sets next state IDLE and Done.
  - Serial_in is sampled live every cycle.
- Start and Shift are ignored while in RUN. A Start is not queued.
- Shift in IDLE: one shift using live Dir/Mode.
- Count may exceed WIDTH. All shifts are performed (rotate wraps; logical leaves all fill).
- Reset values, from async assertion: Data_out 0, Serial_out 0, Busy 0, Done 0, state IDLE, remaining 0.
- Reset mid-burst: immediate return to the reset state; no Done.

## Timing
- Start accepted at edge k with Count = N > 0:
  - Busy = 1 after edge k.
  - Shifts occur at edges k+1 … k+N.
  - After edge k+N: Busy = 0 and Done = 1 for exactly one cycle.
- Count = 0: Done = 1 for the one cycle after edge k; Busy stays 0.
- A new Start may be accepted in the cycle where Done = 1, since the FSM is already IDLE. Back-to-back bursts are therefore gapless.
- Manual Shift or Load: result visible on Data_out after the same edge (1-cycle latency).
- Busy, Done and Serial_out are registered outputs; there are no combinational paths from inputs to outputs.
- Reset_n is deasserted synchronously to Clk by the system; the block assumes no metastability handling.

## Structure
- Package shift_pkg:
  - typedef enum logic [1:0] shift_mode_t {SM_LOGIC, SM_ARITH, SM_ROT, SM_SERIAL}.
  - typedef enum logic state_t {S_IDLE, S_RUN}.
  - Constants DIR_RIGHT = 0, DIR_LEFT = 1.
- Sub-module shift_step: a combinational function of data, dir, mode and serial_in. It returns the next data and the outgoing bit.
  - It is shared by the manual and burst paths so fill rules exist once.
- Top: FSM, remaining-count register, latched dir/mode, and data/Serial_out/Done registers.

## Test plan
All scenarios use WIDTH = 16.
- Load 0x8001; Start, Count 4, Dir left, Mode rotate → Busy for 4 cycles, then Data_out 0x0018, Done one cycle, Serial_out 0.
- Load 0x8000; Start, Count 3, right, arithmetic → sequence 0xC000, 0xE000, 0xF000; Done after the 3rd shift.
- Load 0x0000; Serial_in = 1; Start, Count 16, right, serial → Data_out 0xFFFF; Serial_out 0.
- Load 0x00FF; manual Shift left, logical, 8 single cycles → 0xFF00.
  - Then Start, Count 0 → Done pulses next cycle, Busy stays 0, data 0xFF00.
- Load 0x1234; Start, Count 10, right, logical; Load 0xABCD on the 3rd RUN cycle → Data_out 0xABCD, Busy 0 next cycle, no Done.
  - A Start issued during RUN is ignored; a Start in the Done cycle is accepted.
- Burst in progress; assert Reset_n = 0 between edges → outputs 0 immediately. After release, Shift left, logical on 0 → Data_out 0, Serial_out 0.
